// File: rtl/uart_loader_ctrl.sv
// Loader command sequencer: parses LOAD/STATUS/START bytes from the UART, packs
// big-endian 16-bit words into the program FIFO and returns one response byte per command.
module uart_loader_ctrl #(
    parameter logic [19:0] TIMEOUT  = 20'd1000000,
    parameter logic [7:0]  ACK_BYTE = 8'hA5,
    parameter logic [7:0]  NAK_BYTE = 8'hEE
) (
    input  logic        clk_cmt,
    input  logic        rst,
    input  logic        received,
    input  logic [7:0]  rx_byte,
    input  logic        recv_error,
    input  logic        is_transmitting,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    input  logic        fifo_full,
    input  logic        fifo_empty,
    output logic [15:0] fifo_din,
    output logic        fifo_wr_en,
    output logic        start_pulse,
    output logic        busy,
    output logic [8:0]  word_cnt,
    output logic        err_overflow,
    output logic        err_proto
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_HI, S_LO, S_WR, S_START, S_RESP
    } state_t;

    state_t      state;
    logic [8:0]  remaining;
    logic [19:0] tmo_cnt;
    logic        in_cmd;

    assign in_cmd = (state == S_LEN) || (state == S_HI) || (state == S_LO);
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk_cmt) begin
        if (rst) begin
            state        <= S_IDLE;
            remaining    <= 9'd0;
            tmo_cnt      <= 20'd0;
            transmit     <= 1'b0;
            tx_byte      <= 8'd0;
            fifo_din     <= 16'd0;
            fifo_wr_en   <= 1'b0;
            start_pulse  <= 1'b0;
            word_cnt     <= 9'd0;
            err_overflow <= 1'b0;
            err_proto    <= 1'b0;
        end else begin
            fifo_wr_en  <= 1'b0;
            start_pulse <= 1'b0;

            if (in_cmd)
                tmo_cnt <= received ? 20'd0 : tmo_cnt + 20'd1;
            else
                tmo_cnt <= 20'd0;

            // Framing errors and stalls abort the command; any half-built word is discarded
            if ((recv_error && state != S_RESP) || (in_cmd && tmo_cnt == TIMEOUT)) begin
                err_proto <= 1'b1;
                tx_byte   <= NAK_BYTE;
                state     <= S_RESP;
            end else begin
                case (state)
                    S_IDLE: if (received) begin
                        case (rx_byte)
                            8'h80: begin
                                word_cnt     <= 9'd0;
                                err_overflow <= 1'b0;
                                state        <= S_LEN;
                            end
                            8'h40: begin
                                tx_byte <= {4'b0, err_proto, err_overflow, fifo_full, fifo_empty};
                                state   <= S_RESP;
                            end
                            8'h20: begin
                                start_pulse <= 1'b1;
                                state       <= S_START;
                            end
                            default: begin
                                err_proto <= 1'b1;
                                tx_byte   <= NAK_BYTE;
                                state     <= S_RESP;
                            end
                        endcase
                    end
                    S_LEN: if (received) begin
                        // a length byte of 0 encodes 256 words
                        remaining <= {(rx_byte == 8'd0), rx_byte};
                        state     <= S_HI;
                    end
                    S_HI: if (received) begin
                        fifo_din[15:8] <= rx_byte;
                        state          <= S_LO;
                    end
                    S_LO: if (received) begin
                        fifo_din[7:0] <= rx_byte;
                        state         <= S_WR;
                    end
                    S_WR: begin
                        if (!fifo_full) begin
                            fifo_wr_en <= 1'b1;
                            if (word_cnt != 9'd256)
                                word_cnt <= word_cnt + 9'd1;
                        end else begin
                            err_overflow <= 1'b1;
                        end
                        remaining <= remaining - 9'd1;
                        if (remaining == 9'd1) begin
                            tx_byte <= (err_overflow || fifo_full) ? NAK_BYTE : ACK_BYTE;
                            state   <= S_RESP;
                        end else begin
                            state <= S_HI;
                        end
                    end
                    S_START: begin
                        tx_byte <= ACK_BYTE;
                        state   <= S_RESP;
                    end
                    S_RESP: begin
                        // request once the transmitter is free, release when it takes the byte
                        if (!transmit) begin
                            if (!is_transmitting)
                                transmit <= 1'b1;
                        end else if (is_transmitting) begin
                            transmit <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Directed bench for uart_loader_ctrl: byte-level command stimulus, a small UART
// transmitter responder and FIFO write capture, checked against hand-computed values.
module tb_uart_loader_ctrl;

    logic        clk_cmt = 1'b0;
    logic        rst = 1'b1;
    logic        received = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        recv_error = 1'b0;
    logic        is_transmitting = 1'b0;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        fifo_full = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_din;
    logic        fifo_wr_en;
    logic        start_pulse;
    logic        busy;
    logic [8:0]  word_cnt;
    logic        err_overflow;
    logic        err_proto;

    uart_loader_ctrl #(.TIMEOUT(20'd100), .ACK_BYTE(8'hA5), .NAK_BYTE(8'hEE)) dut (
        .clk_cmt(clk_cmt), .rst(rst), .received(received), .rx_byte(rx_byte),
        .recv_error(recv_error), .is_transmitting(is_transmitting), .transmit(transmit),
        .tx_byte(tx_byte), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .start_pulse(start_pulse),
        .busy(busy), .word_cnt(word_cnt), .err_overflow(err_overflow), .err_proto(err_proto)
    );

    always #5 clk_cmt = ~clk_cmt;

    int n_chk = 0;
    int n_pass = 0;
    int tx_count = 0;
    int sp_cnt = 0;
    int tx_hold = 0;
    logic [7:0]  last_tx = 8'd0;
    logic [15:0] wq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // transmitter responder: accepts a byte, then stays busy for a few cycles
    always @(negedge clk_cmt) begin
        if (rst) begin
            is_transmitting = 1'b0;
            tx_hold = 0;
        end else if (tx_hold > 0) begin
            tx_hold--;
            if (tx_hold == 0) is_transmitting = 1'b0;
        end else if (transmit && !is_transmitting) begin
            last_tx = tx_byte;
            tx_count++;
            is_transmitting = 1'b1;
            tx_hold = 5;
        end
    end

    always @(negedge clk_cmt) begin
        if (fifo_wr_en) wq.push_back(fifo_din);
        if (start_pulse) sp_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_cmt); #1;
        received = 1'b1;
        rx_byte  = b;
        @(posedge clk_cmt); #1;
        received = 1'b0;
        repeat (4) @(posedge clk_cmt);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk_cmt);
            if (!busy && !is_transmitting) break;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    int tx0;

    initial begin
        repeat (3) @(posedge clk_cmt);
        @(negedge clk_cmt);
        chk("rst transmit", transmit, 0);
        chk("rst tx_byte", tx_byte, 0);
        chk("rst outputs", {fifo_wr_en, start_pulse, busy, err_overflow, err_proto}, 0);
        chk("rst word_cnt", word_cnt, 0);
        chk("rst fifo_din", fifo_din, 0);
        @(posedge clk_cmt); #1 rst = 1'b0;

        // STATUS / unknown / STATUS
        send_byte(8'h40); wait_idle("status idle");
        chk("status1 byte", last_tx, 8'h01);
        chk("status1 count", tx_count, 1);
        send_byte(8'h55); wait_idle("unknown idle");
        chk("unknown nak", last_tx, 8'hEE);
        chk("unknown err_proto", err_proto, 1);
        send_byte(8'h40); wait_idle("status2 idle");
        chk("status2 byte", last_tx, 8'h09);

        // START
        sp_cnt = 0;
        send_byte(8'h20); wait_idle("start idle");
        chk("start pulse cycles", sp_cnt, 1);
        chk("start ack", last_tx, 8'hA5);
        chk("start busy", busy, 0);

        // LOAD two words
        fifo_empty = 1'b0;
        wq.delete(); tx0 = tx_count;
        send_byte(8'h80); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
        wait_idle("load2 idle");
        chk("load2 writes", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("load2 w0", wq[0], 16'h1234);
            chk("load2 w1", wq[1], 16'hABCD);
        end
        chk("load2 word_cnt", word_cnt, 2);
        chk("load2 ack", last_tx, 8'hA5);
        chk("load2 handshakes", tx_count - tx0, 1);

        // LOAD with FIFO full from the second word
        wq.delete();
        send_byte(8'h80); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h11);
        fifo_full = 1'b1;
        send_byte(8'h22); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h33);
        wait_idle("ovf idle");
        fifo_full = 1'b0;
        chk("ovf writes", wq.size(), 1);
        if (wq.size() == 1) chk("ovf w0", wq[0], 16'h1111);
        chk("ovf flag", err_overflow, 1);
        chk("ovf nak", last_tx, 8'hEE);
        chk("ovf word_cnt", word_cnt, 1);

        // inter-byte timeout, then a clean load
        wq.delete();
        send_byte(8'h80); send_byte(8'h01); send_byte(8'h12);
        wait_idle("tmo idle");
        chk("tmo writes", wq.size(), 0);
        chk("tmo nak", last_tx, 8'hEE);
        chk("tmo err_proto", err_proto, 1);
        send_byte(8'h80); send_byte(8'h01); send_byte(8'h00); send_byte(8'h07);
        wait_idle("post-tmo idle");
        chk("post-tmo writes", wq.size(), 1);
        if (wq.size() == 1) chk("post-tmo w0", wq[0], 16'h0007);
        chk("post-tmo ack", last_tx, 8'hA5);
        chk("load clears ovf", err_overflow, 0);

        // length 0 means 256 words
        wq.delete();
        send_byte(8'h80); send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            send_byte(i[7:0]);
            send_byte(~i[7:0]);
        end
        wait_idle("len0 idle");
        chk("len0 writes", wq.size(), 256);
        chk("len0 word_cnt", word_cnt, 256);
        if (wq.size() == 256) begin
            chk("len0 first", wq[0], 16'h00FF);
            chk("len0 last", wq[255], 16'hFF00);
        end
        chk("len0 ack", last_tx, 8'hA5);

        // recv_error while waiting for a high byte
        wq.delete();
        send_byte(8'h80); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
        @(posedge clk_cmt); #1 recv_error = 1'b1;
        @(posedge clk_cmt); #1 recv_error = 1'b0;
        wait_idle("rxerr idle");
        chk("rxerr writes", wq.size(), 1);
        chk("rxerr nak", last_tx, 8'hEE);
        chk("rxerr word_cnt", word_cnt, 1);

        // reset in the middle of a word
        wq.delete(); tx0 = tx_count;
        send_byte(8'h80); send_byte(8'h01); send_byte(8'h55);
        @(posedge clk_cmt); #1 rst = 1'b1;
        repeat (2) @(posedge clk_cmt);
        @(negedge clk_cmt);
        chk("midrst outputs", {transmit, fifo_wr_en, start_pulse, busy, err_overflow, err_proto}, 0);
        chk("midrst tx_byte", tx_byte, 0);
        chk("midrst word_cnt", word_cnt, 0);
        @(posedge clk_cmt); #1 rst = 1'b0;
        repeat (20) @(posedge clk_cmt);
        @(negedge clk_cmt);
        chk("midrst no write", wq.size(), 0);
        chk("midrst no transmit", tx_count - tx0, 0);
        chk("midrst busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
